// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus payload types plus the arbiter's state encoding and limits.
// Consumed by cbus_arbiter / cbus_arb_pick (policy macro CBUS_ARB_RR_EN).
package cbus_arbiter_pkg;

  localparam int unsigned CBUS_ADDR_W = 32;
  localparam int unsigned CBUS_DATA_W = 64;
  localparam int unsigned CBUS_STRB_W = CBUS_DATA_W / 8;
  localparam int unsigned CBUS_LEN_W  = 8;

  localparam int unsigned CBUS_ARB_MAX_REQ = 8;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    logic [2:0]             size;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_DATA_W-1:0] data;
    logic [CBUS_LEN_W-1:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cbus_arb_pick.sv
// Combinational winner selection for cbus_arbiter.
// CBUS_ARB_RR_EN selects round-robin from rr; otherwise lowest valid index wins.
module cbus_arb_pick
  import cbus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  assign any = |valid;

`ifdef CBUS_ARB_RR_EN
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  // Rotate so bit 0 is the rr position; first set bit is the offset from rr.
  assign rot = NUM_REQ'({valid, valid} >> rr);

  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    sum = (IDX_W + 1)'(rr) + (IDX_W + 1)'(off);
    if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
      winner = IDX_W'(sum - (IDX_W + 1)'(NUM_REQ));
    end else begin
      winner = IDX_W'(sum);
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^rr;

  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) winner = IDX_W'(i);
    end
  end
`endif

endmodule

// File: rtl/cbus_arbiter.sv
// Shares one cbus master port among NUM_REQ requesters, grant locked per burst.
// Arbitration policy: fixed priority, or round-robin when CBUS_ARB_RR_EN is defined.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  cbus_req_t                  ireqs  [NUM_REQ],
  output cbus_resp_t                 oresps [NUM_REQ],
  output cbus_req_t                  oreq,
  input  cbus_resp_t                 iresp,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic [NUM_REQ-1:0] valid;
  logic [IDX_W-1:0]   rr_q;
  logic [IDX_W-1:0]   winner;
  logic               any;
  logic               burst_done;

  always_comb begin
    valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid[i] = ireqs[i].valid;
    end
  end

  assign burst_done = iresp.ready && iresp.last;

  cbus_arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid  (valid),
    .rr     (rr_q),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus bus steering; only the granted requester sees the bus.
  always_comb begin
    state_d = state_q;
    oreq    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      oresps[j] = '0;
    end
    case (state_q)
      IDLE: begin
        if (any) state_d = BUSY;
      end
      BUSY: begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (grant_idx == IDX_W'(j)) begin
            oreq      = ireqs[j];
            oresps[j] = iresp;
          end
        end
        if (burst_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == BUSY);

  // Grant is captured on BUSY entry and cleared on the final beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_idx <= '0;
      rr_q      <= '0;
    end else if (state_q == IDLE && any) begin
      grant_idx <= winner;
      rr_q      <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
    end else if (state_q == BUSY && burst_done) begin
      grant_idx <= '0;
    end
  end

endmodule
